btn_debounce: RTL and testbench

Debounces one raw, active-low push button and turns it into clean, single-cycle event pulses for the LED counter stage and other control logic.
- Sits directly upstream of the LED counter: `press_o` / `long_o` drive its step and clear controls; `btn_level_o` is available as a steady level.
- Contains a 2-FF input synchronizer, a 4-state debounce FSM and a hold timer for long-press and auto-repeat.

---
 rtl/btn_debounce_if.sv | 28 ++
 rtl/btn_debounce.sv | 154 +++++++++++++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw active-low button in, clean level and event pulses out.
// The debouncer takes the slave side; whatever drives the button and consumes the events takes the master side.
interface btn_debounce_if;
   logic btn_ni;
   logic btn_level_o;
   logic press_o;
   logic release_o;
   logic long_o;
   logic repeat_o;

   modport master (
      output btn_ni,
      input  btn_level_o,
      input  press_o,
      input  release_o,
      input  long_o,
      input  repeat_o
   );

   modport slave (
      input  btn_ni,
      output btn_level_o,
      output press_o,
      output release_o,
      output long_o,
      output repeat_o
   );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer with press/release/long-press events; auto-repeat pulses are built only
// when BTN_AUTOREPEAT_EN is defined, otherwise repeat_o is tied low.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int LONG_CYCLES     = 13500000,
   parameter int REPEAT_CYCLES   = 2700000
) (
   input logic          clk,
   input logic          rst_i,
   btn_debounce_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_HELD         = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES);

   logic          ff1;
   logic          ff2;
   logic          s;
   logic [1:0]    state;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          long_q;
   logic          hold_active;
   logic          accept_release;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ff1 <= 1'b1;
         ff2 <= 1'b1;
      end else begin
         ff1 <= bus.btn_ni;
         ff2 <= ff1;
      end
   end

   assign s              = ~ff2;
   assign hold_active    = (state == ST_HELD) || (state == ST_RELEASE_WAIT);
   assign accept_release = (state == ST_RELEASE_WAIT) && !s && (dcnt == D_LAST);

   // Debounce FSM plus hold timer; a release accepted this cycle overrides any long-press event.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         dcnt      <= '0;
         hcnt      <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s) begin
                  state <= ST_PRESS_WAIT;
                  dcnt  <= D_ONE;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s) begin
                  state <= ST_IDLE;
                  dcnt  <= '0;
               end else if (dcnt == D_LAST) begin
                  state   <= ST_HELD;
                  press_q <= 1'b1;
                  level_q <= 1'b1;
                  hcnt    <= '0;
               end else begin
                  dcnt <= dcnt + D_ONE;
               end
            end
            ST_HELD: begin
               if (!s) begin
                  state <= ST_RELEASE_WAIT;
                  dcnt  <= D_ONE;
               end
            end
            default: begin
               if (s) begin
                  state <= ST_HELD;
               end else if (dcnt == D_LAST) begin
                  state     <= ST_IDLE;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
                  hcnt      <= '0;
               end else begin
                  dcnt <= dcnt + D_ONE;
               end
            end
         endcase

         if (hold_active && !accept_release && (hcnt != H_LAST)) begin
            hcnt <= hcnt + H_ONE;
            if ((hcnt + H_ONE) == H_LAST) begin
               long_q <= 1'b1;
            end
         end
      end
   end

   assign bus.btn_level_o = level_q;
   assign bus.press_o     = press_q;
   assign bus.release_o   = release_q;
   assign bus.long_o      = long_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPW-1:0] R_ONE  = RPW'(1);
   localparam logic [RPW-1:0] R_LAST = RPW'(REPEAT_CYCLES);

   logic [RPW-1:0] rcnt;
   logic           repeat_q;

   // The repeat timer only runs once the hold timer has saturated, i.e. after long_o has fired.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         rcnt     <= '0;
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= 1'b0;
         if (accept_release || !hold_active) begin
            rcnt <= '0;
         end else if (hcnt == H_LAST) begin
            if ((rcnt + R_ONE) == R_LAST) begin
               rcnt     <= '0;
               repeat_q <= 1'b1;
            end else begin
               rcnt <= rcnt + R_ONE;
            end
         end
      end
   end

   assign bus.repeat_o = repeat_q;
`else
   assign bus.repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
// Repeat expectations follow BTN_AUTOREPEAT_EN as seen by this compilation.
module tb_btn_debounce;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_i;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   btn_debounce_if bus ();

   btn_debounce #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk  (clk),
      .rst_i(rst_i),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until press_o (which=0) or release_o (which=1) is seen; n=-1 if the budget runs out.
   task automatic wait_pulse(input int which, input int limit, output int n);
      int i;
      i = 0;
      n = -1;
      while (n < 0 && i < limit) begin
         i++;
         tick();
         if ((which == 0 && bus.press_o === 1'b1) || (which == 1 && bus.release_o === 1'b1)) n = i;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      bus.btn_ni = 1'b1;
      repeat (3) tick();
      checks++;
      if ({bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected 00000",
                  {bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o});
      end
      rst_i = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got %b expected 00000",
                  {bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o});
      end
   endtask

   task automatic test_clean_press();
      int n;
      int longs;
      longs = 0;
      // btn drops after edge E, so ff1 first captures 0 at E+1 and press lands at E+1+6 = 7 ticks.
      bus.btn_ni = 1'b0;
      wait_pulse(0, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL press_latency: got %0d expected 7", n); end
      checks++;
      if (bus.btn_level_o !== 1'b1) begin errors++; $display("[TB] FAIL level_on_press: got %b expected 1", bus.btn_level_o); end
      tick();
      checks++;
      if (bus.press_o !== 1'b0) begin errors++; $display("[TB] FAIL press_single_cycle: got %b expected 0", bus.press_o); end
      repeat (4) begin
         tick();
         if (bus.long_o === 1'b1) longs++;
      end
      bus.btn_ni = 1'b1;
      wait_pulse(1, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL release_latency: got %0d expected 7", n); end
      checks++;
      if (bus.btn_level_o !== 1'b0) begin errors++; $display("[TB] FAIL level_on_release: got %b expected 0", bus.btn_level_o); end
      checks++;
      if (longs !== 0) begin errors++; $display("[TB] FAIL short_press_long: got %0d expected 0", longs); end
      repeat (5) tick();
   endtask

   task automatic test_press_glitch();
      int pulses;
      int level_hi;
      pulses = 0;
      level_hi = 0;
      bus.btn_ni = 1'b0;
      repeat (3) tick();
      bus.btn_ni = 1'b1;
      repeat (15) begin
         tick();
         if (bus.press_o === 1'b1 || bus.release_o === 1'b1 || bus.long_o === 1'b1 || bus.repeat_o === 1'b1) pulses++;
         if (bus.btn_level_o !== 1'b0) level_hi++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulses); end
      checks++;
      if (level_hi !== 0) begin errors++; $display("[TB] FAIL glitch_level: got %0d expected 0", level_hi); end
   endtask

   task automatic test_release_bounce();
      int n;
      int long_at;
      int rels;
      long_at = -1;
      rels = 0;
      bus.btn_ni = 1'b0;
      wait_pulse(0, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL bounce_press_latency: got %0d expected 7", n); end
      for (int t = 1; t <= 25; t++) begin
         tick();
         if (bus.release_o === 1'b1) rels++;
         if (bus.long_o === 1'b1 && long_at < 0) long_at = t;
         if (t == 3) bus.btn_ni = 1'b1;
         if (t == 5) bus.btn_ni = 1'b0;
      end
      checks++;
      if (rels !== 0) begin errors++; $display("[TB] FAIL bounce_release: got %0d expected 0", rels); end
      checks++;
      if (long_at !== L) begin errors++; $display("[TB] FAIL bounce_long_time: got %0d expected %0d", long_at, L); end
      checks++;
      if (bus.btn_level_o !== 1'b1) begin errors++; $display("[TB] FAIL bounce_level: got %b expected 1", bus.btn_level_o); end
      bus.btn_ni = 1'b1;
      wait_pulse(1, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL bounce_final_release: got %0d expected 7", n); end
      repeat (5) tick();
   endtask

   // Release is timed to land on press+52, the same edge as the fourth repeat, so repeat must be suppressed there.
   task automatic test_hold();
      int n;
      logic [4:0] exp_v;
      logic [4:0] got_v;
      bus.btn_ni = 1'b0;
      wait_pulse(0, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL hold_press_latency: got %0d expected 7", n); end
      for (int t = 1; t <= 52; t++) begin
         tick();
         exp_v[4] = (t < 52);
         exp_v[3] = 1'b0;
         exp_v[2] = (t == 52);
         exp_v[1] = (t == L);
         exp_v[0] = RPT_EN && (t == L + R || t == L + 2 * R || t == L + 3 * R);
         got_v = {bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL hold_t%0d level/press/release/long/repeat: got %b expected %b", t, got_v, exp_v);
         end
         if (t == 45) bus.btn_ni = 1'b1;
      end
      repeat (5) tick();
   endtask

   task automatic test_reset_mid_press();
      int n;
      int stray;
      stray = 0;
      bus.btn_ni = 1'b0;
      wait_pulse(0, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL rst_press_latency: got %0d expected 7", n); end
      repeat (10) tick();
      rst_i = 1'b1;
      #1;
      checks++;
      if ({bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o} !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL async_reset_outputs: got %b expected 00000",
                  {bus.btn_level_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o});
      end
      repeat (2) begin
         tick();
         if (bus.release_o !== 1'b0 || bus.btn_level_o !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin errors++; $display("[TB] FAIL reset_no_release: got %0d expected 0", stray); end
      rst_i = 1'b0;
      // The first edge after release is where ff1 first captures the held-low button.
      wait_pulse(0, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL repress_after_reset: got %0d expected 7", n); end
      checks++;
      if (bus.btn_level_o !== 1'b1) begin errors++; $display("[TB] FAIL repress_level: got %b expected 1", bus.btn_level_o); end
      bus.btn_ni = 1'b1;
      wait_pulse(1, 20, n);
      checks++;
      if (n !== 7) begin errors++; $display("[TB] FAIL repress_release: got %0d expected 7", n); end
   endtask

   initial begin
      rst_i = 1'b1;
      bus.btn_ni = 1'b1;
      test_reset();
      test_clean_press();
      test_press_glitch();
      test_release_bounce();
      test_hold();
      test_reset_mid_press();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
